// File: rtl/data_mem_responder.sv
// Data-memory responder for the MEM-stage busywait handshake: fixed-latency
// byte/half/word loads and stores against an internal word array.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ_EN,
  input  logic        WRITE_EN,
  input  logic [2:0]  FUNC3,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITE_DATA,
  output logic [31:0] READ_DATA,
  output logic        BUSYWAIT,
  output logic        MISALIGNED
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [31:0]      mem [DEPTH_WORDS];
  logic [1:0]       state_r;
  logic [3:0]       cnt_r;
  logic [IDX_W+1:0] addr_r;
  logic [2:0]       func3_r;
  logic [31:0]      wdata_r;
  logic             wr_r;
  logic [31:0]      rdata_r;
  logic             mis_r;
  logic             req_s;
  logic             commit_s;
  logic             busy_s;
  logic [IDX_W-1:0] idx_s;
  logic [1:0]       lane_s;
  logic [31:0]      word_s;
  logic             unused_s;

  // Extract and extend the addressed byte/half; unlisted codes fall back to a word.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [2:0] f3,
                                               input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = 8'd0;
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  res = {{24{b[7]}}, b};
      3'b001:  res = {{16{h[15]}}, h};
      3'b100:  res = {24'd0, b};
      3'b101:  res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Merge store data into the old word on the selected byte lanes.
  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] data,
                                              input logic [2:0] f3, input logic [1:0] lane);
    logic [31:0] res;
    res = old;
    case (f3[1:0])
      2'b00: begin
        case (lane)
          2'd0:    res[7:0]   = data[7:0];
          2'd1:    res[15:8]  = data[7:0];
          2'd2:    res[23:16] = data[7:0];
          2'd3:    res[31:24] = data[7:0];
          default: res = old;
        endcase
      end
      2'b01: begin
        if (lane[1]) res[31:16] = data[15:0];
        else         res[15:0]  = data[15:0];
      end
      default: res = data;
    endcase
    return res;
  endfunction

  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lane);
    logic res;
    case (f3[1:0])
      2'b00:   res = 1'b0;
      2'b01:   res = lane[0];
      default: res = |lane;
    endcase
    return res;
  endfunction

  assign req_s    = READ_EN | WRITE_EN;
  assign commit_s = (state_r == ST_BUSY) && (cnt_r == 4'd0);
  assign idx_s    = addr_r[IDX_W+1:2];
  assign lane_s   = addr_r[1:0];
  assign word_s   = mem[idx_s];
  assign unused_s = ^ADDRESS[31:IDX_W+2];

  // Busywait is combinational in IDLE so the initiator stalls in the request cycle itself.
  always_comb begin
    busy_s = 1'b0;
    if (RESET) begin
      busy_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: busy_s = req_s;
        ST_BUSY: busy_s = 1'b1;
        default: busy_s = 1'b0;
      endcase
    end
  end

  // Access FSM: latch request, count down latency, commit, acknowledge.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      addr_r  <= '0;
      func3_r <= 3'd0;
      wdata_r <= 32'd0;
      wr_r    <= 1'b0;
      rdata_r <= 32'd0;
      mis_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          mis_r <= 1'b0;
          if (req_s) begin
            addr_r  <= ADDRESS[IDX_W+1:0];
            func3_r <= FUNC3;
            wdata_r <= WRITE_DATA;
            wr_r    <= WRITE_EN;
            cnt_r   <= CNT_INIT;
            state_r <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (cnt_r == 4'd0) begin
            mis_r   <= is_misaligned(func3_r, lane_s);
            state_r <= ST_ACK;
            if (!wr_r) rdata_r <= load_extract(word_s, func3_r, lane_s);
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        ST_ACK: begin
          mis_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          mis_r   <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Array write; state is held in IDLE by reset, so an aborted access never commits.
  always_ff @(posedge CLK) begin
    if (commit_s && wr_r) mem[idx_s] <= store_merge(word_s, wdata_r, func3_r, lane_s);
  end

  assign READ_DATA  = rdata_r;
  assign BUSYWAIT   = busy_s;
  assign MISALIGNED = mis_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: one LATENCY=4 instance for function,
// plus LATENCY=1 and LATENCY=15 instances for the latency sweep.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rd_en [3];
  logic        wr_en [3];
  logic [2:0]  func3 = 3'd0;
  logic [31:0] address = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata [3];
  logic        bw [3];
  logic        mis [3];
  int          checks = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) dut0 (
    .CLK(clk), .RESET(rst), .READ_EN(rd_en[0]), .WRITE_EN(wr_en[0]), .FUNC3(func3),
    .ADDRESS(address), .WRITE_DATA(wdata), .READ_DATA(rdata[0]), .BUSYWAIT(bw[0]),
    .MISALIGNED(mis[0]));
  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
    .CLK(clk), .RESET(rst), .READ_EN(rd_en[1]), .WRITE_EN(wr_en[1]), .FUNC3(func3),
    .ADDRESS(address), .WRITE_DATA(wdata), .READ_DATA(rdata[1]), .BUSYWAIT(bw[1]),
    .MISALIGNED(mis[1]));
  data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(15)) dut2 (
    .CLK(clk), .RESET(rst), .READ_EN(rd_en[2]), .WRITE_EN(wr_en[2]), .FUNC3(func3),
    .ADDRESS(address), .WRITE_DATA(wdata), .READ_DATA(rdata[2]), .BUSYWAIT(bw[2]),
    .MISALIGNED(mis[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One access: busywait cycles counted until the ACK cycle, where data and flag are captured.
  task automatic do_access(input int k, input logic we, input logic re, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output int busy, output logic [31:0] rd, output logic ms);
    int n;
    busy = 0;
    rd = 32'd0;
    ms = 1'b0;
    @(negedge clk);
    wr_en[k] = we; rd_en[k] = re; func3 = f3; address = a; wdata = wd;
    for (n = 0; n < 40; n++) begin
      #1;
      if (bw[k]) busy++;
      else begin
        rd = rdata[k];
        ms = mis[k];
        break;
      end
      @(negedge clk);
    end
    wr_en[k] = 1'b0; rd_en[k] = 1'b0;
    check("ack_timeout", {31'd0, n < 40}, 32'd1);
  endtask

  initial begin
    int          busy;
    logic [31:0] rd;
    logic        ms;
    logic [11:0] pattern;
    for (int i = 0; i < 3; i++) begin rd_en[i] = 1'b0; wr_en[i] = 1'b0; end

    // Reset state, busywait gated even with a request present
    #1 rst = 1'b1;
    rd_en[0] = 1'b1;
    #2;
    check("rst_bw", {31'd0, bw[0]}, 32'd0);
    check("rst_rdata", rdata[0], 32'd0);
    check("rst_mis", {31'd0, mis[0]}, 32'd0);
    rd_en[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_access(0, 1'b1, 1'b0, 3'b010, 32'h10, 32'hDEADBEEF, busy, rd, ms);
    check("sw_busy", busy, 32'd5);
    do_access(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'd0, busy, rd, ms);
    check("lw_busy", busy, 32'd5);
    check("lw_data", rd, 32'hDEADBEEF);
    check("lw_mis", {31'd0, ms}, 32'd0);

    do_access(0, 1'b0, 1'b1, 3'b000, 32'h13, 32'd0, busy, rd, ms);
    check("lb", rd, 32'hFFFFFFDE);
    do_access(0, 1'b0, 1'b1, 3'b100, 32'h13, 32'd0, busy, rd, ms);
    check("lbu", rd, 32'h000000DE);
    do_access(0, 1'b0, 1'b1, 3'b001, 32'h12, 32'd0, busy, rd, ms);
    check("lh", rd, 32'hFFFFDEAD);
    do_access(0, 1'b0, 1'b1, 3'b101, 32'h10, 32'd0, busy, rd, ms);
    check("lhu", rd, 32'h0000BEEF);

    // Sub-word stores; upper store-data bits must be ignored, READ_DATA untouched
    do_access(0, 1'b1, 1'b0, 3'b000, 32'h11, 32'hAABBCC55, busy, rd, ms);
    check("sb_keeps_rdata", rd, 32'h0000BEEF);
    do_access(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'd0, busy, rd, ms);
    check("sb_result", rd, 32'hDEAD55EF);
    do_access(0, 1'b1, 1'b0, 3'b001, 32'h12, 32'hFFFF1234, busy, rd, ms);
    do_access(0, 1'b0, 1'b1, 3'b010, 32'h10, 32'd0, busy, rd, ms);
    check("sh_result", rd, 32'h123455EF);

    do_access(0, 1'b0, 1'b1, 3'b010, 32'h11, 32'd0, busy, rd, ms);
    check("mis_lw_flag", {31'd0, ms}, 32'd1);
    check("mis_lw_data", rd, 32'h123455EF);
    @(negedge clk); #1;
    check("mis_one_cycle", {31'd0, mis[0]}, 32'd0);
    do_access(0, 1'b0, 1'b1, 3'b001, 32'h13, 32'd0, busy, rd, ms);
    check("mis_lh_flag", {31'd0, ms}, 32'd1);
    check("mis_lh_data", rd, 32'h00001234);
    do_access(0, 1'b0, 1'b1, 3'b010, 32'h410, 32'd0, busy, rd, ms);
    check("wrap_data", rd, 32'h123455EF);
    check("wrap_mis", {31'd0, ms}, 32'd0);

    // Reset during BUSY aborts the store
    do_access(0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h11112222, busy, rd, ms);
    @(negedge clk);
    wr_en[0] = 1'b1; func3 = 3'b010; address = 32'h20; wdata = 32'hCAFEF00D;
    #1 check("abort_req_bw", {31'd0, bw[0]}, 32'd1);
    repeat (2) @(negedge clk);
    wr_en[0] = 1'b0;
    rst = 1'b1;
    #1;
    check("abort_bw", {31'd0, bw[0]}, 32'd0);
    check("abort_rdata", rdata[0], 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_access(0, 1'b0, 1'b1, 3'b010, 32'h20, 32'd0, busy, rd, ms);
    check("abort_old_value", rd, 32'h11112222);

    // Back-to-back store then load with the request held continuously
    @(negedge clk);
    wr_en[0] = 1'b1; func3 = 3'b010; address = 32'h30; wdata = 32'h0BADCAFE;
    for (int i = 0; i < 12; i++) begin
      #1;
      pattern[11-i] = bw[0];
      if (i == 5) begin rd_en[0] = 1'b1; wr_en[0] = 1'b0; end
      if (i == 11) rd = rdata[0];
      @(negedge clk);
    end
    rd_en[0] = 1'b0;
    check("b2b_pattern", {20'd0, pattern}, {20'd0, 12'b111110111110});
    check("b2b_data", rd, 32'h0BADCAFE);

    // Both enables: store only; undefined FUNC3 acts as word
    do_access(0, 1'b1, 1'b1, 3'b010, 32'h40, 32'h00000077, busy, rd, ms);
    check("both_no_load", rd, 32'h0BADCAFE);
    do_access(0, 1'b0, 1'b1, 3'b011, 32'h40, 32'd0, busy, rd, ms);
    check("f3_011_word", rd, 32'h00000077);

    // Latency sweep
    do_access(1, 1'b1, 1'b0, 3'b010, 32'h4, 32'hA5A5A5A5, busy, rd, ms);
    check("lat1_sw_busy", busy, 32'd2);
    do_access(1, 1'b0, 1'b1, 3'b010, 32'h4, 32'd0, busy, rd, ms);
    check("lat1_lw_busy", busy, 32'd2);
    check("lat1_lw_data", rd, 32'hA5A5A5A5);
    do_access(2, 1'b1, 1'b0, 3'b010, 32'h4, 32'h5A5A1234, busy, rd, ms);
    check("lat15_sw_busy", busy, 32'd16);
    do_access(2, 1'b0, 1'b1, 3'b010, 32'h4, 32'd0, busy, rd, ms);
    check("lat15_lw_busy", busy, 32'd16);
    check("lat15_lw_data", rd, 32'h5A5A1234);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
